// File: rtl/multiword_add_sequencer_if.sv
// Handshake and operand bus for multiword_add_sequencer.
// The producer side (in_*, a, b, cin) and consumer side (out_*, sum, cout)
// share one bundle; the sequencer takes the slave view.
// Optional feature macro: MWADD_SUB_EN adds the 'sub' request bit.
interface multiword_add_sequencer_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef MWADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, a, b, cin,
`ifdef MWADD_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef MWADD_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder: sums WORDS*N-bit operands over WORDS cycles using
// one shared N-bit carry-lookahead adder, least-significant chunk first,
// with the carry registered between chunks.
// Optional feature macro: MWADD_SUB_EN (sub=1 computes A - B; cout=1 means
// no borrow).
module multiword_add_sequencer #(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst,
  multiword_add_sequencer_if.slave bus
);
  localparam int W  = N * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  opA_q, opA_d;
  logic [W-1:0]  opB_q, opB_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  logic [N-1:0]  chunkA, chunkB, gen, prop, addSum;
  logic [N:0]    carries;
  logic          addCout;
  logic          term;

  // Shared N-bit adder: each carry is a flat sum of generate/propagate
  // products of the current chunk rather than a rippled chain.
  always_comb begin
    chunkA  = opA_q[int'(k_q)*N +: N];
    chunkB  = opB_q[int'(k_q)*N +: N];
    gen     = chunkA & chunkB;
    prop    = chunkA ^ chunkB;
    carries = '0;
    term    = 1'b0;
    for (int i = 0; i <= N; i++) begin
      term = carry_q;
      for (int j = 0; j < i; j++) begin
        term = term & prop[j];
      end
      carries[i] = term;
      for (int j = 0; j < i; j++) begin
        term = gen[j];
        for (int m = j + 1; m < i; m++) begin
          term = term & prop[m];
        end
        carries[i] = carries[i] | term;
      end
    end
    addSum  = prop ^ carries[N-1:0];
    addCout = carries[N];
  end

  // Next-state logic: accept in IDLE, step one chunk per cycle in RUN,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opA_d = bus.a;
`ifdef MWADD_SUB_EN
          opB_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          opB_d   = bus.b;
          carry_d = bus.cin;
`endif
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(k_q)*N +: N] = addSum;
        carry_d = addCout;
        if (k_q == KLAST) begin
          cout_d  = addCout;
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears
  // everything so nothing leaks into the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (WORDS=4 and WORDS=1).
// Expected results are pushed when an operation is accepted and popped when
// the DUT hands a result over.
module tb_multiword_add_sequencer;
  localparam int N     = 16;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic clk = 1'b0;
  logic rst;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int lastAccept  = 0;
  int prevAccept  = 0;

  logic [W:0] sbQ[$];
  logic [W:0] expRes;
  logic [W:0] exp3;
  logic [16:0] expS;

  multiword_add_sequencer_if #(.W(W)) bus ();
  multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  multiword_add_sequencer_if #(.W(16)) busS ();
  multiword_add_sequencer #(.N(16), .WORDS(1)) dutS (
    .clk(clk),
    .rst(rst),
    .bus(busS)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W-1:0] bEff;
    logic         cEff;
    bEff = sub ? ~b : b;
    cEff = sub ? 1'b1 : cin;
    return {1'b0, a} + {1'b0, bEff} + {{W{1'b0}}, cEff};
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub);
    int  waitCycles;
    bit  accepted;
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef MWADD_SUB_EN
    bus.sub = sub;
`endif
    bus.in_valid = 1'b1;
    accepted     = 1'b0;
    waitCycles   = 0;
    while (!accepted && waitCycles < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
      waitCycles++;
    end
    checkOutput("accept", 128'(accepted), 128'd1);
    if (accepted) begin
      prevAccept = lastAccept;
      lastAccept = cyc;
      sbQ.push_back(model(a, b, cin, sub));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sbQ.size() != 0 || bus.busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", 128'(n < 200), 128'd1);
  endtask

  // Scoreboard: compare each result in the cycle its handshake completes.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checkOutput("sb_nonempty", 128'(sbQ.size() != 0), 128'd1);
      if (sbQ.size() != 0) begin
        expRes = sbQ.pop_front();
        checkOutput("sum", 128'(bus.sum), 128'(expRes[W-1:0]));
        checkOutput("cout", 128'(bus.cout), 128'(expRes[W]));
      end
    end
  end

  // Hard stop in case the sequence itself gets stuck.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.cin        = 1'b0;
    bus.out_ready  = 1'b0;
    busS.in_valid  = 1'b0;
    busS.a         = '0;
    busS.b         = '0;
    busS.cin       = 1'b0;
    busS.out_ready = 1'b0;
`ifdef MWADD_SUB_EN
    bus.sub  = 1'b0;
    busS.sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 128'(bus.in_ready), 128'd0);
    checkOutput("rst_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("rst_busy", 128'(bus.busy), 128'd0);
    checkOutput("rst_sum", 128'(bus.sum), 128'd0);
    checkOutput("rst_cout", 128'(bus.cout), 128'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 128'(bus.in_ready), 128'd1);

    $display("[TB] scenario 1: all-ones plus one, latency");
    bus.out_ready = 1'b1;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    for (int i = 1; i < WORDS; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t1_ov_early", 128'(bus.out_valid), 128'd0);
    end
    @(posedge clk);
    #1;
    checkOutput("t1_ov_on_time", 128'(bus.out_valid), 128'd1);
    waitDrain();

    $display("[TB] scenario 2: chunkwise add with cin");
    applyStimulus(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] scenario 3: backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
    exp3 = model(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("t3_done", 128'(bus.out_valid), 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = i[0];
      bus.a        = {$urandom(), $urandom()};
      bus.b        = {$urandom(), $urandom()};
      bus.cin      = i[1];
      #2;
      checkOutput("t3_out_valid", 128'(bus.out_valid), 128'd1);
      checkOutput("t3_in_ready", 128'(bus.in_ready), 128'd0);
      checkOutput("t3_sum_hold", 128'(bus.sum), 128'(exp3[W-1:0]));
      checkOutput("t3_cout_hold", 128'(bus.cout), 128'(exp3[W]));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t3_in_ready_after", 128'(bus.in_ready), 128'd1);
    checkOutput("t3_busy_after", 128'(bus.busy), 128'd0);
    checkOutput("t3_sb_empty", 128'(sbQ.size()), 128'd0);

    $display("[TB] scenario 4: reset mid-operation");
    applyStimulus(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sbQ.pop_back());
    checkOutput("t4_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("t4_sum", 128'(bus.sum), 128'd0);
    checkOutput("t4_busy", 128'(bus.busy), 128'd0);
    checkOutput("t4_cout", 128'(bus.cout), 128'd0);
    applyStimulus(64'd3, 64'd4, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] scenario 5: back-to-back");
    applyStimulus(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b0);
    applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    checkOutput("t5_spacing_1", 128'(lastAccept - prevAccept), 128'(WORDS + 2));
    applyStimulus(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
    checkOutput("t5_spacing_2", 128'(lastAccept - prevAccept), 128'(WORDS + 2));
    waitDrain();

    $display("[TB] scenario 5b: WORDS=1");
    expS = {1'b0, 16'hFFFF} + 17'd1;
    busS.a        = 16'hFFFF;
    busS.b        = 16'h0001;
    busS.cin      = 1'b0;
    busS.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("s_in_ready", 128'(busS.in_ready), 128'd1);
    @(posedge clk);
    #1;
    busS.in_valid = 1'b0;
    checkOutput("s_ov_early", 128'(busS.out_valid), 128'd0);
    @(posedge clk);
    #1;
    checkOutput("s_ov_on_time", 128'(busS.out_valid), 128'd1);
    checkOutput("s_sum", 128'(busS.sum), 128'(expS[15:0]));
    checkOutput("s_cout", 128'(busS.cout), 128'(expS[16]));
    busS.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("s_busy_after", 128'(busS.busy), 128'd0);

`ifdef MWADD_SUB_EN
    $display("[TB] scenario 6: subtract");
    applyStimulus(64'd5, 64'd7, 1'b1, 1'b1);
    applyStimulus(64'd7, 64'd5, 1'b0, 1'b1);
    applyStimulus(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0);
    waitDrain();
`endif

    waitDrain();
    checkOutput("sb_empty_end", 128'(sbQ.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end
endmodule
